// File: rtl/data_mem_2p.sv
// Simple-dual-port data memory with registered reads, a valid flag and a
// built-in clear sequencer that zeroes every word after reset or on request.
module data_mem_2p #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int WR_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    // cnt_r carries one extra bit so the terminal compare never wraps
    localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W:0]   cnt_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_word_s;

    // Port acceptance: accesses are honoured only in READY and never under rst
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (!rst && (state_r == ST_READY)) begin
            wr_acc_s = wr_en;
            rd_acc_s = rd_en;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
    end

    // Single memory write port shared by the clear sweep and the user port
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = wr_data;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r[ADDR_W-1:0];
            mem_wdata_s = DATA_ZERO;
        end else begin
            mem_we_s = wr_acc_s;
        end
    end

    // Read word selection including the read-during-write bypass
    always_comb begin
        rd_word_s = mem_r[rd_addr];
        if ((WR_FIRST != 0) && wr_acc_s && (wr_addr == rd_addr)) begin
            rd_word_s = wr_data;
        end else begin
            rd_word_s = mem_r[rd_addr];
        end
    end

    // Storage array, written only on the clock edge
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Clear/ready sequencer and registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_CLEAR;
            cnt_r    <= CNT_ZERO;
            ready    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= DATA_ZERO;
        end else begin
            rd_valid <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data <= rd_word_s;
            end
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_READY;
                        ready   <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        state_r <= ST_CLEAR;
                        cnt_r   <= CNT_ZERO;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= CNT_ZERO;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    data_mem_2p_chk #(.DATA_W(DATA_W)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

endmodule

// Output protocol properties of the memory, kept apart from the datapath.
module data_mem_2p_chk #(
    parameter int DATA_W = 8
) (
    input logic              clk,
    input logic              rst,
    input logic              ready,
    input logic              rd_valid,
    input logic [DATA_W-1:0] rd_data
);

    // A cycle without ready can never produce a read result
    no_valid_when_busy: assert property (@(posedge clk) !ready |=> !rd_valid);

    // Reset clears every registered output
    reset_outputs: assert property (@(posedge clk)
        rst |=> (!ready && !rd_valid && (rd_data == {DATA_W{1'b0}})));

endmodule

// File: tb/tb_data_mem_2p.sv
// Directed scoreboard bench for data_mem_2p: two 8x256 instances (old/new
// read-during-write) driven in lockstep plus one 32x16 instance.
module tb_data_mem_2p;

    logic        clk;
    logic        rst, clr, wr_en, rd_en;
    logic [7:0]  wr_addr, wr_data, rd_addr;
    logic        ready0, ready1, rd_valid0, rd_valid1;
    logic [7:0]  rd_data0, rd_data1;

    logic        b_rst, b_clr, b_wr_en, b_rd_en;
    logic [3:0]  b_wr_addr, b_rd_addr;
    logic [31:0] b_wr_data, b_rd_data;
    logic        b_ready, b_rd_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$], q1[$], qb[$];
    logic [31:0] ea0, ea1, eb;
    bit          mrdy_a = 1'b0, mrdy_b = 1'b0;
    int          mcnt_a = 0, mcnt_b = 0;
    int          n;

    data_mem_2p #(.DATA_W(8), .ADDR_W(8), .WR_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0));

    data_mem_2p #(.DATA_W(8), .ADDR_W(8), .WR_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1));

    data_mem_2p #(.DATA_W(32), .ADDR_W(4), .WR_FIRST(0)) u2 (
        .clk(clk), .rst(b_rst), .clr(b_clr), .ready(b_ready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid));

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string tag, ref logic [31:0] q[$],
                              input logic vld, input logic [31:0] dat);
        if (q.size() > 0) begin
            check({tag, "_valid"}, {31'd0, vld}, 32'd1);
            check({tag, "_data"}, dat, q.pop_front());
        end else begin
            check({tag, "_valid_idle"}, {31'd0, vld}, 32'd0);
        end
    endtask

    // One clock: score accepted reads, advance the ready model, then compare
    task automatic tick();
        if (!rst && mrdy_a && rd_en) begin
            q0.push_back(ea0);
            q1.push_back(ea1);
        end
        if (!b_rst && mrdy_b && b_rd_en) qb.push_back(eb);
        if (rst) begin mrdy_a = 1'b0; mcnt_a = 0; end
        else if (!mrdy_a) begin if (mcnt_a == 255) mrdy_a = 1'b1; mcnt_a++; end
        else if (clr) begin mrdy_a = 1'b0; mcnt_a = 0; end
        if (b_rst) begin mrdy_b = 1'b0; mcnt_b = 0; end
        else if (!mrdy_b) begin if (mcnt_b == 15) mrdy_b = 1'b1; mcnt_b++; end
        else if (b_clr) begin mrdy_b = 1'b0; mcnt_b = 0; end
        @(posedge clk);
        #1;
        check("ready0", {31'd0, ready0}, {31'd0, mrdy_a});
        check("ready1", {31'd0, ready1}, {31'd0, mrdy_a});
        check("b_ready", {31'd0, b_ready}, {31'd0, mrdy_b});
        check_port("u0", q0, rd_valid0, {24'd0, rd_data0});
        check_port("u1", q1, rd_valid1, {24'd0, rd_data1});
        check_port("u2", qb, b_rd_valid, b_rd_data);
    endtask

    task automatic wait_ready(input bit sel_b, input int start, input int exp_n, input string tag);
        int cnt;
        cnt = start;
        while (((sel_b ? b_ready : ready0) !== 1'b1) && (cnt < 2000)) begin
            tick();
            cnt++;
        end
        check(tag, cnt, exp_n);
    endtask

    task automatic op(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                      input logic r, input logic [7:0] ra,
                      input logic [7:0] e0, input logic [7:0] e1);
        wr_en = w; wr_addr = wa; wr_data = wd;
        rd_en = r; rd_addr = ra;
        ea0 = {24'd0, e0}; ea1 = {24'd0, e1};
        tick();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
        b_rst = 1'b1; b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
        b_wr_addr = 4'h0; b_rd_addr = 4'h0; b_wr_data = 32'h0;
        ea0 = 32'h0; ea1 = 32'h0; eb = 32'h0;

        // Initial reset and sweep, then junk preload
        tick();
        rst = 1'b0;
        wait_ready(1'b0, 0, 256, "power_clear_len");
        op(1'b1, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h00, 8'h00);
        op(1'b1, 8'h80, 8'hC3, 1'b0, 8'h00, 8'h00, 8'h00);
        op(1'b1, 8'hFF, 8'h99, 1'b1, 8'h80, 8'hC3, 8'hC3);

        // 1: reset pulse clears outputs and every location
        wr_en = 1'b0; rd_en = 1'b0; rst = 1'b1;
        tick();
        check("rst_rd_data0", {24'd0, rd_data0}, 32'd0);
        rst = 1'b0;
        wait_ready(1'b0, 0, 256, "rst_clear_len");
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);

        // 2: write/read back-to-back, then rd_data holds
        op(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 8'h00, 8'h00);
        op(1'b1, 8'hFF, 8'h3C, 1'b0, 8'h00, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'hA5, 8'hA5);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h3C, 8'h3C);
        op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        check("hold_rd_data0", {24'd0, rd_data0}, 32'h3C);

        // 3: read-during-write on the same address
        op(1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 8'h00, 8'h00);
        op(1'b1, 8'h20, 8'h22, 1'b1, 8'h20, 8'h11, 8'h22);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 8'h22, 8'h22);
        op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);

        // 4: clear pulse with same-cycle accesses, then ignored accesses while clearing
        op(1'b1, 8'h05, 8'h44, 1'b0, 8'h00, 8'h00, 8'h00);
        clr = 1'b1;
        op(1'b1, 8'h05, 8'h77, 1'b1, 8'h05, 8'h44, 8'h77);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) op(1'b1, 8'h01, 8'hEE, 1'b1, 8'h10, 8'hFF, 8'hFF);
        wr_en = 1'b0; rd_en = 1'b0;
        wait_ready(1'b0, 10, 256, "clr_clear_len");
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);

        // 5: reset during a sweep restarts it from zero
        op(1'b1, 8'h10, 8'h5C, 1'b0, 8'h00, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h5C, 8'h5C);
        rd_en = 1'b0; rst = 1'b1;
        tick();
        check("rst2_rd_data0", {24'd0, rd_data0}, 32'd0);
        check("rst2_rd_data1", {24'd0, rd_data1}, 32'd0);
        rst = 1'b0;
        op(1'b1, 8'h10, 8'h5C, 1'b0, 8'h00, 8'h00, 8'h00);
        wr_en = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        rst = 1'b1; rd_en = 1'b1; rd_addr = 8'h10;
        tick();
        check("rst3_rd_data0", {24'd0, rd_data0}, 32'd0);
        rst = 1'b0; rd_en = 1'b0;
        wait_ready(1'b0, 0, 256, "midsweep_clear_len");
        op(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h00, 8'h00);
        op(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);

        // 6: 32-bit x 16 instance
        tick();
        b_rst = 1'b0;
        wait_ready(1'b1, 0, 16, "b_clear_len");
        b_wr_en = 1'b1; b_wr_addr = 4'hF; b_wr_data = 32'hDEADBEEF;
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b1; b_rd_addr = 4'hF; eb = 32'hDEADBEEF;
        tick();
        b_rd_addr = 4'h0; eb = 32'h0;
        tick();
        b_rd_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_2p.md
Name: data_mem_2p

Overview:
Parametrised simple-dual-port data memory, the next generation of the team's 8-bit x 256 data memory. It has one write port and one read port with independent addresses, all synchronous to `clk`. Reads are registered and carry a valid flag. A built-in clear sequencer zeroes every location after reset, or on request. The block sits between the datapath load/store unit and the register file writeback.

Parameters:
DATA_W, 8, width of each word in bits (>=1)
ADDR_W, 8, address width in bits; depth = 2**ADDR_W
WR_FIRST, 0, read-during-write on the same address: 1 returns new data, 0 returns old data

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset; also starts a clear sweep
clr  input  1  single-cycle pulse; starts a clear sweep when the block is ready
ready  output  1  high when the ports accept accesses (not clearing)
wr_en  input  1  write strobe; honoured only when ready=1
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_en  input  1  read strobe; honoured only when ready=1
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  read data, valid when rd_valid=1
rd_valid  output  1  one-cycle pulse, one cycle after an accepted read

Behaviour:
- Storage: 2**ADDR_W words x DATA_W bits. Memory is written only on the rising edge of `clk`; there are no combinational or level-sensitive writes.
- FSM has two states, CLEAR and READY. It powers up in CLEAR with the sweep counter at 0.
- When `rst`=1 at an edge:
  - state <= CLEAR, sweep counter <= 0;
  - ready <= 0, rd_valid <= 0, rd_data <= 0.
  - rst has priority over every other input.
- Behaviour in CLEAR:
  - each cycle writes 0 to mem[cnt], then cnt <= cnt+1;
  - after writing the last address (2**ADDR_W - 1), state <= READY and ready <= 1 on the same edge;
  - the sweep covers every address, including the top one;
  - a full clear takes exactly 2**ADDR_W cycles from the first edge with rst low;
  - wr_en, rd_en and clr are ignored;
  - rst held high keeps cnt at 0; rst asserted mid-sweep restarts the sweep from 0.
- clr=1 in READY at an edge:
  - state <= CLEAR, cnt <= 0, ready <= 0;
  - any wr_en/rd_en in that same cycle is still honoured (accesses go first, then the clear starts).
- Write in READY: wr_en=1 gives mem[wr_addr] <= wr_data at that edge.
- Read in READY: rd_en=1 gives, at that edge:
  - rd_data <= mem[rd_addr];
  - rd_valid <= 1.
  - Latency is exactly 1 cycle; rd_valid is 0 in any cycle with no accepted read.
- rd_data holds its last value when no read is accepted. It returns to 0 only on rst.
- Same-cycle read and write to the same address:
  - WR_FIRST=1: rd_data = wr_data;
  - WR_FIRST=0: rd_data = the prior contents.
  - Different addresses never interact.
- Simultaneous rd_en and wr_en are both honoured every cycle (full throughput, no stalls in READY).
- Addresses are unsigned and exactly ADDR_W wide, so no out-of-range access exists. cnt is ADDR_W+1 bits wide so the terminal test does not wrap.

Test Plan:
1. Reset + clear (ADDR_W=8): preload junk via backdoor, pulse rst 1 cycle. Required: ready=0 for exactly 256 cycles, then 1. Reading addresses 0, 128 and 255 returns 0x00 each, with rd_valid one cycle after rd_en.
2. Write/read and latency: write 0xA5 to 0x10 and 0x3C to 0xFF, then read 0x10 then 0xFF back-to-back. Required: rd_data=0xA5 and then 0x3C on consecutive cycles, rd_valid high for 2 cycles.
3. Read-during-write: mem[0x20]=0x11; same cycle wr 0x20<=0x22 and rd 0x20. Required: rd_data=0x11 with WR_FIRST=0, 0x22 with WR_FIRST=1; the following read of 0x20 returns 0x22 in both cases.
4. Clear pulse with same-cycle access: in READY, clr=1 together with wr 0x05<=0x77 and rd 0x05 (old value 0x44). Required: rd_data=0x44 and rd_valid=1, ready drops the next cycle, and reads after ready returns give 0x00. wr_en/rd_en during CLEAR produce no rd_valid and no memory change.
5. Reset mid-sweep: assert rst at sweep cycle 100. Required: the sweep restarts, ready rises 256 cycles after rst deasserts, and rd_data=0 / rd_valid=0 right after rst.
6. Parameter sweep: DATA_W=32, ADDR_W=4. Required: the clear takes 16 cycles, and a write then read of 0xDEADBEEF at address 0xF returns 0xDEADBEEF.
